// File: rtl/t_ff_counter_param_if.sv
// Control/status bundle for the T-cell counter: the master drives the controls, the slave returns q and wrap.
interface t_ff_counter_param_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] t_in;
  logic             load;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] q;
  logic             wrap;

  modport master (output en, mode, t_in, load, d_in, input q, wrap);
  modport slave  (input en, mode, t_in, load, d_in, output q, wrap);
endinterface

// File: rtl/t_ff_counter_param.sv
// N-bit register of T cells (q ^= tmask) with hold/up/down/toggle modes, modulus, load and a registered wrap pulse.
// Optional macro T_CNT_SATURATE_EN: up/down stop at the ends and keep wrap high instead of wrapping around.
module t_ff_counter_param #(
  parameter int     WIDTH     = 4,
  parameter longint MOD       = 16,
  parameter longint RESET_VAL = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  t_ff_counter_param_if.slave     bus
);
  // Compares run at WIDTH+1 bits so MOD = 2^WIDTH is representable.
  localparam logic [WIDTH:0]   L_MOD  = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0]   L_MAX1 = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH-1:0] L_MAX  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] L_RST  = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH:0]   w_q1;
  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH-1:0] w_tmask;
  logic [WIDTH-1:0] w_ld;
  logic             w_wrap_nxt;

  assign w_q1 = {1'b0, r_q};
  assign w_ld = ({1'b0, bus.d_in} >= L_MOD) ? L_MAX : bus.d_in;

  always_comb begin
    w_tgt      = r_q;
    w_wrap_nxt = 1'b0;
    case (bus.mode)
      2'b01: begin
        if (w_q1 < L_MAX1) begin
          w_tgt = r_q + WIDTH'(1);
        end else if (w_q1 == L_MAX1) begin
`ifdef T_CNT_SATURATE_EN
          w_tgt = r_q;
`else
          w_tgt = '0;
`endif
          w_wrap_nxt = 1'b1;
        end else begin
          w_tgt = '0;
        end
      end
      2'b10: begin
        if (w_q1 == '0) begin
`ifdef T_CNT_SATURATE_EN
          w_tgt = r_q;
`else
          w_tgt = L_MAX;
`endif
          w_wrap_nxt = 1'b1;
        end else if (w_q1 >= L_MOD) begin
          w_tgt = L_MAX;
        end else begin
          w_tgt = r_q - WIDTH'(1);
        end
      end
      2'b11:   w_tgt = r_q ^ bus.t_in;
      default: w_tgt = r_q;
    endcase
  end

  // Every counting step is reduced to the set of bits that must toggle.
  assign w_tmask = r_q ^ w_tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= L_RST;
      r_wrap <= 1'b0;
    end else if (bus.load) begin
      r_q    <= w_ld;
      r_wrap <= 1'b0;
    end else if (bus.en) begin
      r_q    <= r_q ^ w_tmask;
      r_wrap <= w_wrap_nxt;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign bus.q    = r_q;
  assign bus.wrap = r_wrap;
endmodule
